// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point classes, flag bit positions and format helpers
// for the pipelined multiplier.
`default_nettype none

package fp_pkg;

   typedef enum logic [1:0] {
      FP_ZERO = 2'd0,
      FP_NORM = 2'd1,
      FP_INF  = 2'd2,
      FP_NAN  = 2'd3
   } fp_class_e;

   localparam int FLAG_INEXACT   = 0;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_INVALID   = 3;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
   function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
      logic [63:0] r;
      r = ((64'd1 << exp_w) - 64'd1) << man_w;
      r = r | (64'd1 << (man_w - 1));
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fp_norm_round.sv
// fp_norm_round: combinational normalise of the raw mantissa product followed
// by round-to-nearest-even.
`default_nettype none

module fp_norm_round
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic        [2*MAN_W+1:0] prod,
   input  logic signed [EXP_W+1:0]   exp_in,
   output logic        [MAN_W-1:0]   man_out,
   output logic signed [EXP_W+1:0]   exp_out,
   output logic                      inexact
);

   localparam logic signed [EXP_W+1:0] ONE = {{(EXP_W+1){1'b0}}, 1'b1};

   logic        [MAN_W-1:0] man_trunc;
   logic        [MAN_W:0]   man_rnd;
   logic signed [EXP_W+1:0] exp_norm;
   logic                    guard;
   logic                    sticky;
   logic                    round_up;

   always_comb begin
      man_trunc = prod[2*MAN_W-1:MAN_W];
      guard     = prod[MAN_W-1];
      sticky    = |prod[MAN_W-2:0];
      exp_norm  = exp_in;
      // Product in [2,4): drop one more bit and bump the exponent.
      if (prod[2*MAN_W+1]) begin
         man_trunc = prod[2*MAN_W:MAN_W+1];
         guard     = prod[MAN_W];
         sticky    = |prod[MAN_W-1:0];
         exp_norm  = exp_in + ONE;
      end
      round_up = guard && (sticky || man_trunc[0]);
      man_rnd  = {1'b0, man_trunc} + {{MAN_W{1'b0}}, round_up};
      // Carry out leaves the fraction at zero, so only the exponent moves.
      man_out  = man_rnd[MAN_W-1:0];
      exp_out  = man_rnd[MAN_W] ? exp_norm + ONE : exp_norm;
      inexact  = guard || sticky;
   end

endmodule

`default_nettype wire

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage pipelined floating-point multiplier with RNE rounding,
// exception flags, tag pass-through and a global-stall valid/ready handshake.
`default_nettype none

module fp_mult_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [EXP_W+MAN_W:0]   a_i,
   input  logic [EXP_W+MAN_W:0]   b_i,
   input  logic [TAG_W-1:0]       tag_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [EXP_W+MAN_W:0]   y_o,
   output logic [TAG_W-1:0]       tag_o,
   output logic [3:0]             flags_o
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int PW = 2 * MAN_W + 2;
   localparam int XW = EXP_W + 2;
   localparam logic signed [XW-1:0] BIAS     = XW'(fp_bias(EXP_W));
   localparam logic signed [XW-1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
   localparam logic signed [XW-1:0] EXP_ZERO = '0;
   localparam logic [W-1:0]         QNAN     = W'(fp_qnan(EXP_W, MAN_W));

   function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
      if (e == '0) return FP_ZERO;
      if (e == '1) return (m == '0) ? FP_INF : FP_NAN;
      return FP_NORM;
   endfunction

   logic advance;
   assign advance    = !out_valid_o || out_ready_i;
   assign in_ready_o = advance;

   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] ma, mb;
   fp_class_e        cls_a, cls_b;
   logic [XW-1:0]    exp_sum;
   logic [PW-1:0]    prod;
   logic             snan_in;

   assign ea      = a_i[W-2:MAN_W];
   assign eb      = b_i[W-2:MAN_W];
   assign ma      = a_i[MAN_W-1:0];
   assign mb      = b_i[MAN_W-1:0];
   assign cls_a   = classify(ea, ma);
   assign cls_b   = classify(eb, mb);
   assign exp_sum = {2'b00, ea} + {2'b00, eb} - BIAS;
   assign prod    = {{(MAN_W+1){1'b0}}, 1'b1, ma} * {{(MAN_W+1){1'b0}}, 1'b1, mb};
   assign snan_in = (cls_a == FP_NAN && !ma[MAN_W-1]) || (cls_b == FP_NAN && !mb[MAN_W-1]);

   logic                 s1_valid, s1_sign, s1_snan;
   logic [TAG_W-1:0]     s1_tag;
   logic signed [XW-1:0] s1_exp;
   logic [PW-1:0]        s1_prod;
   fp_class_e            s1_cls_a, s1_cls_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_snan  <= 1'b0;
         s1_tag   <= '0;
         s1_exp   <= '0;
         s1_prod  <= '0;
         s1_cls_a <= FP_ZERO;
         s1_cls_b <= FP_ZERO;
      end else if (advance) begin
         s1_valid <= in_valid_i;
         s1_sign  <= a_i[W-1] ^ b_i[W-1];
         s1_snan  <= snan_in;
         s1_tag   <= tag_i;
         s1_exp   <= exp_sum;
         s1_prod  <= prod;
         s1_cls_a <= cls_a;
         s1_cls_b <= cls_b;
      end
   end

   logic [MAN_W-1:0]     nr_man;
   logic signed [XW-1:0] nr_exp;
   logic                 nr_inexact;

   fp_norm_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_norm_round (
      .prod    (s1_prod),
      .exp_in  (s1_exp),
      .man_out (nr_man),
      .exp_out (nr_exp),
      .inexact (nr_inexact)
   );

   logic                 s2_valid, s2_sign, s2_snan, s2_inexact;
   logic [TAG_W-1:0]     s2_tag;
   logic signed [XW-1:0] s2_exp;
   logic [MAN_W-1:0]     s2_man;
   fp_class_e            s2_cls_a, s2_cls_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid   <= 1'b0;
         s2_sign    <= 1'b0;
         s2_snan    <= 1'b0;
         s2_inexact <= 1'b0;
         s2_tag     <= '0;
         s2_exp     <= '0;
         s2_man     <= '0;
         s2_cls_a   <= FP_ZERO;
         s2_cls_b   <= FP_ZERO;
      end else if (advance) begin
         s2_valid   <= s1_valid;
         s2_sign    <= s1_sign;
         s2_snan    <= s1_snan;
         s2_inexact <= nr_inexact;
         s2_tag     <= s1_tag;
         s2_exp     <= nr_exp;
         s2_man     <= nr_man;
         s2_cls_a   <= s1_cls_a;
         s2_cls_b   <= s1_cls_b;
      end
   end

   logic [W-1:0] y_c;
   logic [3:0]   flags_c;
   logic         any_nan, any_inf, any_zero, inf_zero;

   always_comb begin
      any_nan  = (s2_cls_a == FP_NAN)  || (s2_cls_b == FP_NAN);
      any_inf  = (s2_cls_a == FP_INF)  || (s2_cls_b == FP_INF);
      any_zero = (s2_cls_a == FP_ZERO) || (s2_cls_b == FP_ZERO);
      inf_zero = any_inf && any_zero;
      y_c      = {s2_sign, s2_exp[EXP_W-1:0], s2_man};
      flags_c  = '0;
      if (any_nan || inf_zero) begin
         y_c                   = QNAN;
         flags_c[FLAG_INVALID] = inf_zero || s2_snan;
      end else if (any_inf) begin
         y_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (any_zero) begin
         y_c = {s2_sign, {(W-1){1'b0}}};
      end else if (s2_exp >= EXP_MAX) begin
         y_c                    = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_c[FLAG_OVERFLOW] = 1'b1;
         flags_c[FLAG_INEXACT]  = 1'b1;
      end else if (s2_exp <= EXP_ZERO) begin
         y_c                     = {s2_sign, {(W-1){1'b0}}};
         flags_c[FLAG_UNDERFLOW] = 1'b1;
         flags_c[FLAG_INEXACT]   = 1'b1;
      end else begin
         flags_c[FLAG_INEXACT] = s2_inexact;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_o <= 1'b0;
         y_o         <= '0;
         tag_o       <= '0;
         flags_o     <= '0;
      end else if (advance) begin
         out_valid_o <= s2_valid;
         y_o         <= y_c;
         tag_o       <= s2_tag;
         flags_o     <= flags_c;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed scoreboard bench for the pipelined FP multiplier
// (single-precision configuration).
`default_nettype none

module tb_fp_mult_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] a_i, b_i;
   logic [3:0]  tag_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] y_o;
   logic [3:0]  tag_o;
   logic [3:0]  flags_o;

   fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .a_i         (a_i),
      .b_i         (b_i),
      .tag_i       (tag_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .y_o         (y_o),
      .tag_o       (tag_o),
      .flags_o     (flags_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] y;
      logic [3:0]  tag;
      logic [3:0]  flags;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
   logic        st_prev = 1'b0;
   logic [31:0] y_prev;
   logic [3:0]  tag_prev, flags_prev;

   always @(negedge clk) begin
      if (rst_n) begin
         n_vec++;
         assert (in_ready_o === (!out_valid_o || out_ready_i)) else begin
            n_err++;
            $error("FAIL in_ready obs=%b exp=%b", in_ready_o, !out_valid_o || out_ready_i);
         end
         if (st_prev) begin
            n_vec++;
            assert ({out_valid_o, y_o, tag_o, flags_o} === {1'b1, y_prev, tag_prev, flags_prev}) else begin
               n_err++;
               $error("FAIL stall_hold obs=%b/%h/%h/%b exp=1/%h/%h/%b",
                      out_valid_o, y_o, tag_o, flags_o, y_prev, tag_prev, flags_prev);
            end
         end
         if (out_valid_o && out_ready_i) begin
            n_vec++;
            assert (sb.size() != 0) else begin
               n_err++;
               $error("FAIL unexpected_out obs y=%h tag=%h exp none", y_o, tag_o);
            end
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               n_vec++;
               assert ({y_o, tag_o, flags_o} === e) else begin
                  n_err++;
                  $error("FAIL result_tag%0h obs y=%h tag=%h flags=%b exp y=%h tag=%h flags=%b",
                         e.tag, y_o, tag_o, flags_o, e.y, e.tag, e.flags);
               end
            end
         end
         st_prev    = out_valid_o && !out_ready_i;
         y_prev     = y_o;
         tag_prev   = tag_o;
         flags_prev = flags_o;
      end else begin
         st_prev = 1'b0;
      end
   end

   task automatic drive_ready();
      case (ready_mode)
         1:       out_ready_i = ($urandom_range(0, 1) != 0);
         2:       out_ready_i = 1'b0;
         default: out_ready_i = 1'b1;
      endcase
   endtask

   // Entered and left at posedge+1; expected result is queued when accepted.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                       input logic [31:0] y, input logic [3:0] fl);
      logic acc;
      int   waited;
      acc    = 1'b0;
      waited = 0;
      a_i = a; b_i = b; tag_i = tag; in_valid_i = 1'b1;
      while (!acc && waited < 50) begin
         @(negedge clk);
         acc = in_ready_o;
         if (acc) sb.push_back({y, tag, fl});
         @(posedge clk);
         #1;
         drive_ready();
         waited++;
      end
      in_valid_i = 1'b0;
      if (!acc) begin
         n_vec++;
         assert (acc) else begin
            n_err++;
            $error("FAIL accept_tag%0h obs=0 exp=1", tag);
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         drive_ready();
         n++;
      end
      n_vec++;
      assert (sb.size() == 0) else begin
         n_err++;
         $error("FAIL drain obs=%0d pending exp=0", sb.size());
      end
   endtask

   task automatic check_latency(input string name);
      int lat;
      lat = 1;
      while (lat < 10) begin
         @(negedge clk);
         if (out_valid_o) break;
         lat++;
      end
      @(posedge clk);
      #1;
      n_vec++;
      assert (lat == 3) else begin
         n_err++;
         $error("FAIL %s obs=%0d exp=3", name, lat);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid_i = 1'b0; a_i = '0; b_i = '0; tag_i = '0; out_ready_i = 1'b1;
      #1;
      n_vec++;
      assert ({out_valid_o, y_o, tag_o, flags_o} === 41'd0) else begin
         n_err++;
         $error("FAIL reset_state obs=%b/%h/%h/%b exp=0/0/0/0", out_valid_o, y_o, tag_o, flags_o);
      end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic product and latency on an empty pipe.
      send(32'h40000000, 32'h40400000, 4'h3, 32'h40C00000, 4'b0000);
      check_latency("latency_first");
      // Directed vectors, back to back.
      send(32'hC0000000, 32'h40400000, 4'h1, 32'hC0C00000, 4'b0000);
      send(32'h3F800001, 32'h3F800001, 4'h2, 32'h3F800002, 4'b0001);
      send(32'h3FC00000, 32'h3FC00000, 4'h4, 32'h40100000, 4'b0000);
      send(32'h3FC00000, 32'h3F800001, 4'h5, 32'h3FC00002, 4'b0001);  // tie, odd lsb: round up
      send(32'h3FC00000, 32'h3F800003, 4'h6, 32'h3FC00004, 4'b0001);  // tie, even lsb: keep
      send(32'h7F800000, 32'h00000000, 4'h7, 32'h7FC00000, 4'b1000);
      send(32'h7FC00000, 32'h3F800000, 4'h8, 32'h7FC00000, 4'b0000);
      send(32'h7F800001, 32'h3F800000, 4'h9, 32'h7FC00000, 4'b1000);  // signalling NaN
      send(32'hFF800000, 32'h40000000, 4'hA, 32'hFF800000, 4'b0000);
      send(32'h80000000, 32'h3F800000, 4'hB, 32'h80000000, 4'b0000);
      send(32'h7F000000, 32'h7F000000, 4'hC, 32'h7F800000, 4'b0101);
      send(32'h7F000000, 32'h40000000, 4'hD, 32'h7F800000, 4'b0101);  // exponent exactly all ones
      send(32'h7F000000, 32'h3F800000, 4'hE, 32'h7F000000, 4'b0000);
      send(32'h00800000, 32'h00800000, 4'hF, 32'h00000000, 4'b0011);
      send(32'h00800000, 32'h3F000000, 4'h0, 32'h00000000, 4'b0011);  // exponent exactly zero
      send(32'h80800000, 32'h3F000000, 4'h1, 32'h80000000, 4'b0011);
      send(32'h00800000, 32'h3F800000, 4'h2, 32'h00800000, 4'b0000);
      send(32'h00000001, 32'h3F800000, 4'h3, 32'h00000000, 4'b0000);
      drain();

      // Stream under random backpressure.
      ready_mode = 1;
      send(32'h40000000, 32'h40400000, 4'h8, 32'h40C00000, 4'b0000);
      send(32'h3F800001, 32'h3F800001, 4'h9, 32'h3F800002, 4'b0001);
      send(32'h7F800000, 32'h00000000, 4'hA, 32'h7FC00000, 4'b1000);
      send(32'hC0000000, 32'h40400000, 4'hB, 32'hC0C00000, 4'b0000);
      send(32'h7F000000, 32'h7F000000, 4'hC, 32'h7F800000, 4'b0101);
      send(32'h3FC00000, 32'h3FC00000, 4'hD, 32'h40100000, 4'b0000);
      drain();

      // Fill the pipe against a stalled consumer, then reset mid-cycle.
      ready_mode = 2;
      out_ready_i = 1'b0;
      send(32'h40000000, 32'h40000000, 4'h1, 32'h40800000, 4'b0000);
      send(32'h40400000, 32'h40000000, 4'h2, 32'h40C00000, 4'b0000);
      send(32'h3F800000, 32'h3F800000, 4'h3, 32'h3F800000, 4'b0000);
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      assert ({out_valid_o, y_o, tag_o, flags_o} === 41'd0) else begin
         n_err++;
         $error("FAIL reset_midflight obs=%b/%h/%h/%b exp=0/0/0/0", out_valid_o, y_o, tag_o, flags_o);
      end
      sb.delete();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      ready_mode = 0;
      out_ready_i = 1'b1;
      @(posedge clk);
      #1;
      send(32'h40000000, 32'hC0400000, 4'h6, 32'hC0C00000, 4'b0000);
      check_latency("latency_after_reset");
      repeat (6) @(posedge clk);
      #1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
